// File: rtl/iob_reset_seq.sv
// Parametrised reset sequencer: synchronises and debounces N_READY readiness
// flags, releases N_OUT staged resets in index order, and issues a retry pulse
// with a saturating retry count when the readiness inputs time out.
module iob_reset_seq #(
    parameter int N_READY      = 2,
    parameter int N_OUT        = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_DELAY  = 4,
    parameter int TIMEOUT      = 1024,
    parameter int RETRY_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_READY-1:0] ready_i,
    output logic [N_OUT-1:0]   rst_o,
    output logic               retry_o,
    output logic               timeout_o,
    output logic [7:0]         retry_cnt_o,
    output logic               run_o
);

    localparam int REL_SPAN = STAGE_DELAY * N_OUT;
    localparam int MAX_A    = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
    localparam int MAX_B    = (REL_SPAN > RETRY_CYCLES) ? REL_SPAN : RETRY_CYCLES;
    localparam int MAX_ALL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(MAX_ALL) + 1;

    typedef enum logic [2:0] {
        S_WAIT_READY,
        S_HOLD,
        S_RELEASE,
        S_RUN,
        S_RETRY
    } state_t;

    state_t                                state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0][N_READY-1:0]   sync_q, sync_d;
    logic [N_OUT-1:0]                      rst_out_q, rst_out_d;
    logic                                  retry_q, retry_d;
    logic                                  timeout_q, timeout_d;
    logic [7:0]                            retry_cnt_q, retry_cnt_d;
    logic                                  run_q, run_d;
    logic                                  all_rdy;

    assign all_rdy     = &sync_q[SYNC_STAGES-1];
    assign rst_o       = rst_out_q;
    assign retry_o     = retry_q;
    assign timeout_o   = timeout_q;
    assign retry_cnt_o = retry_cnt_q;
    assign run_o       = run_q;

    // Shift each readiness flag through its synchroniser chain.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = ready_i;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Sequencer next-state, shared counter and registered output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_out_d   = rst_out_q;
        retry_d     = retry_q;
        timeout_d   = timeout_q;
        retry_cnt_d = retry_cnt_q;
        run_d       = run_q;

        case (state_q)
            S_WAIT_READY: begin
                cnt_d     = cnt_q + 1'b1;
                rst_out_d = '1;
                run_d     = 1'b0;
                retry_d   = 1'b0;
                if (all_rdy) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_RETRY;
                    cnt_d     = '0;
                    retry_d   = 1'b1;
                    timeout_d = 1'b1;
                    if (retry_cnt_q != 8'hFF) begin
                        retry_cnt_d = retry_cnt_q + 8'd1;
                    end
                end
            end

            S_HOLD: begin
                if (!all_rdy) begin
                    state_d = S_WAIT_READY;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    cnt_d        = '0;
                    rst_out_d[0] = 1'b0;
                    if (N_OUT == 1) begin
                        state_d = S_RUN;
                        run_d   = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RELEASE: begin
                if (!all_rdy) begin
                    state_d   = S_WAIT_READY;
                    cnt_d     = '0;
                    rst_out_d = '1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    for (int unsigned k = 1; k < N_OUT; k++) begin
                        if (cnt_q == CNT_W'(STAGE_DELAY * k - 1)) begin
                            rst_out_d[k] = 1'b0;
                            if (k == N_OUT - 1) begin
                                state_d = S_RUN;
                                run_d   = 1'b1;
                            end
                        end
                    end
                end
            end

            S_RUN: begin
                if (!all_rdy) begin
                    state_d   = S_WAIT_READY;
                    cnt_d     = '0;
                    rst_out_d = '1;
                    run_d     = 1'b0;
                end
            end

            S_RETRY: begin
                if (cnt_q == CNT_W'(RETRY_CYCLES - 1)) begin
                    state_d = S_WAIT_READY;
                    cnt_d   = '0;
                    retry_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = S_WAIT_READY;
                cnt_d     = '0;
                rst_out_d = '1;
                run_d     = 1'b0;
                retry_d   = 1'b0;
            end
        endcase
    end

    // State, counter, synchronisers and outputs with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WAIT_READY;
            cnt_q       <= '0;
            sync_q      <= '0;
            rst_out_q   <= '1;
            retry_q     <= 1'b0;
            timeout_q   <= 1'b0;
            retry_cnt_q <= '0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            rst_out_q   <= rst_out_d;
            retry_q     <= retry_d;
            timeout_q   <= timeout_d;
            retry_cnt_q <= retry_cnt_d;
            run_q       <= run_d;
        end
    end

endmodule

// File: tb/tb_iob_reset_seq.sv
// Directed bench for iob_reset_seq with default parameters: staged release,
// readiness drops in HOLD/RELEASE/RUN, timeout retries and async reset.
module tb_iob_reset_seq;

    logic       clk;
    logic       rst;
    logic [1:0] ready_i;
    logic [2:0] rst_o;
    logic       retry_o;
    logic       timeout_o;
    logic [7:0] retry_cnt_o;
    logic       run_o;

    int n_checks;
    int n_fail;

    iob_reset_seq #(
        .N_READY      (2),
        .N_OUT        (3),
        .SYNC_STAGES  (2),
        .HOLD_CYCLES  (16),
        .STAGE_DELAY  (4),
        .TIMEOUT      (1024),
        .RETRY_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready_i     (ready_i),
        .rst_o       (rst_o),
        .retry_o     (retry_o),
        .timeout_o   (timeout_o),
        .retry_cnt_o (retry_cnt_o),
        .run_o       (run_o)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector: ready_i value, cycles to apply, expected rst_o/run_o after the
    // last cycle, and whether rst_o must hold that value on every cycle.
    typedef struct packed {
        logic [1:0] ready;
        logic [7:0] ticks;
        logic [2:0] rst;
        logic       run;
        logic       stable;
    } vec_t;

    vec_t vecs [26];

    function automatic logic [13:0] outs();
        return {rst_o, run_o, retry_o, timeout_o, retry_cnt_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: {rst_o,run,retry,timeout,retry_cnt} got %b_%b_%b_%b_%h expected %b_%b_%b_%b_%h",
                     name, idx, act[13:11], act[10], act[9], act[8], act[7:0],
                     exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    initial begin
        logic [2:0] r;
        logic       exp_retry;
        n_checks = 0;
        n_fail   = 0;

        // Staged release, drops in RUN, HOLD glitch, drop during RELEASE.
        vecs[0]  = '{2'b11, 8'd18, 3'b111, 1'b0, 1'b1};
        vecs[1]  = '{2'b11, 8'd1,  3'b110, 1'b0, 1'b0};
        vecs[2]  = '{2'b11, 8'd3,  3'b110, 1'b0, 1'b1};
        vecs[3]  = '{2'b11, 8'd1,  3'b100, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 8'd3,  3'b100, 1'b0, 1'b1};
        vecs[5]  = '{2'b11, 8'd1,  3'b000, 1'b1, 1'b0};
        vecs[6]  = '{2'b11, 8'd5,  3'b000, 1'b1, 1'b1};
        vecs[7]  = '{2'b10, 8'd2,  3'b000, 1'b1, 1'b1};
        vecs[8]  = '{2'b10, 8'd1,  3'b111, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 8'd18, 3'b111, 1'b0, 1'b1};
        vecs[10] = '{2'b11, 8'd1,  3'b110, 1'b0, 1'b0};
        vecs[11] = '{2'b11, 8'd4,  3'b100, 1'b0, 1'b0};
        vecs[12] = '{2'b11, 8'd4,  3'b000, 1'b1, 1'b0};
        vecs[13] = '{2'b00, 8'd3,  3'b111, 1'b0, 1'b0};
        vecs[14] = '{2'b11, 8'd8,  3'b111, 1'b0, 1'b1};
        vecs[15] = '{2'b01, 8'd3,  3'b111, 1'b0, 1'b1};
        vecs[16] = '{2'b11, 8'd18, 3'b111, 1'b0, 1'b1};
        vecs[17] = '{2'b11, 8'd1,  3'b110, 1'b0, 1'b0};
        vecs[18] = '{2'b11, 8'd4,  3'b100, 1'b0, 1'b0};
        vecs[19] = '{2'b11, 8'd4,  3'b000, 1'b1, 1'b0};
        vecs[20] = '{2'b00, 8'd3,  3'b111, 1'b0, 1'b0};
        vecs[21] = '{2'b11, 8'd19, 3'b110, 1'b0, 1'b0};
        vecs[22] = '{2'b10, 8'd1,  3'b110, 1'b0, 1'b0};
        vecs[23] = '{2'b10, 8'd1,  3'b110, 1'b0, 1'b0};
        vecs[24] = '{2'b10, 8'd1,  3'b111, 1'b0, 1'b0};
        vecs[25] = '{2'b10, 8'd5,  3'b111, 1'b0, 1'b1};

        // Reset state.
        rst     = 1'b1;
        ready_i = 2'b00;
        repeat (3) tick();
        check("reset", 0, outs(), {3'b111, 1'b0, 1'b0, 1'b0, 8'd0});

        // Timeout/retry with readiness never asserted.
        rst = 1'b0;
        for (int i = 1; i <= 3000; i++) begin
            tick();
            exp_retry = ((i >= 1024) && (i < 1032)) || ((i >= 2056) && (i < 2064));
            check("retry_trace", i, {rst_o, retry_o, 10'd0},
                  {3'b111, exp_retry, 10'd0});
            if (i == 1023) check("pre_timeout", i, outs(), {3'b111, 1'b0, 1'b0, 1'b0, 8'd0});
            if (i == 1024) check("first_retry", i, outs(), {3'b111, 1'b0, 1'b1, 1'b1, 8'd1});
            if (i == 1032) check("retry_end", i, outs(), {3'b111, 1'b0, 1'b0, 1'b1, 8'd1});
            if (i == 2056) check("second_retry", i, outs(), {3'b111, 1'b0, 1'b1, 1'b1, 8'd2});
            if (i == 3000) check("timeout_end", i, outs(), {3'b111, 1'b0, 1'b0, 1'b1, 8'd2});
        end

        // Reach RUN with the sticky flags still set.
        ready_i = 2'b11;
        repeat (26) tick();
        check("run_sticky_pre", 0, outs(), {3'b100, 1'b0, 1'b0, 1'b1, 8'd2});
        tick();
        check("run_sticky", 0, outs(), {3'b000, 1'b1, 1'b0, 1'b1, 8'd2});

        // Asynchronous reset in RUN, checked between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 0, outs(), {3'b111, 1'b0, 1'b0, 1'b0, 8'd0});
        repeat (2) tick();
        check("async_rst_hold", 0, outs(), {3'b111, 1'b0, 1'b0, 1'b0, 8'd0});

        // Table-driven sequences from a clean reset.
        ready_i = 2'b11;
        rst     = 1'b0;
        for (int v = 0; v < 26; v++) begin
            ready_i = vecs[v].ready;
            for (int t = 0; t < int'(vecs[v].ticks); t++) begin
                tick();
                r = rst_o;
                if (vecs[v].stable) begin
                    check("vec_stable", v, {rst_o, 11'd0}, {vecs[v].rst, 11'd0});
                end else begin
                    check("vec_order", v, {(r == 3'b111 || r == 3'b110 || r == 3'b100 || r == 3'b000), 13'd0},
                          {1'b1, 13'd0});
                end
            end
            check("vec", v, outs(), {vecs[v].rst, vecs[v].run, 1'b0, 1'b0, 8'd0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
